// File: rtl/mfp_ahb_uart_tx_pkg.sv
// Shared constants for the AHB-Lite UART transmitter: register offsets,
// STATUS bit positions and transmit FSM state encodings.
package mfp_ahb_uart_tx_pkg;

    // Register offsets, as decoded from HADDR[3:2]
    localparam logic [1:0] MFP_UART_TX_DATA_OFF   = 2'd0;
    localparam logic [1:0] MFP_UART_TX_STATUS_OFF = 2'd1;

    // STATUS bit positions
    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_PAR   = 4;
    localparam int ST_COUNT = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/mfp_uart_tx_fifo.sv
// Byte FIFO for the UART transmitter. Synchronous, first-word fall-through
// (dout always shows the oldest entry). A push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module mfp_uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage array; no reset needed, occupancy is tracked by count
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mfp_ahb_uart_tx.sv
// AHB-Lite slave UART transmitter. Bytes written to TXDATA are queued and
// sent LSB first on UART_TX. Optional even parity bit when
// MFP_UART_TX_PARITY_EN is defined (11-bit frame, STATUS bit4 = 1);
// otherwise plain 8N1.
module mfp_ahb_uart_tx
    import mfp_ahb_uart_tx_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic        UART_TX
);
    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int FCW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DIV_M1 = CNT_W'(DIV - 1);
`ifdef MFP_UART_TX_PARITY_EN
    localparam logic PAR_PRESENT = 1'b1;
`else
    localparam logic PAR_PRESENT = 1'b0;
`endif

    logic             addr_ok, dp_wr, wr_data, wr_stat, ovf, busy;
    logic [1:0]       dp_addr;
    logic [31:0]      status;
    logic             pop, full, empty;
    logic [7:0]       dout;
    logic [FCW-1:0]   count;
    tx_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_n;
    logic [7:0]       shift, shift_n;
    logic             tx_n;
`ifdef MFP_UART_TX_PARITY_EN
    logic             par, par_n;
`endif
    logic             unused_bits;

    assign unused_bits = ^{HSIZE, HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:8]};
    assign HREADYOUT   = 1'b1;
    assign HRESP       = 1'b0;

    assign addr_ok = HSEL & HTRANS[1] & HREADY;
    assign wr_data = dp_wr && (dp_addr == MFP_UART_TX_DATA_OFF);
    assign wr_stat = dp_wr && (dp_addr == MFP_UART_TX_STATUS_OFF);
    assign busy    = (state != S_IDLE);
    assign status  = {16'b0, 8'(count), 3'b0, PAR_PRESENT, ovf, busy, empty, full};

    mfp_uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .push  (wr_data),
        .pop   (pop),
        .din   (HWDATA[7:0]),
        .dout  (dout),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Address-phase capture; read data is registered here so it is valid in the data phase
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_wr   <= 1'b0;
            dp_addr <= 2'd0;
            HRDATA  <= 32'h0;
        end else begin
            dp_wr   <= addr_ok & HWRITE;
            dp_addr <= HADDR[3:2];
            HRDATA  <= (addr_ok && !HWRITE && HADDR[3:2] == MFP_UART_TX_STATUS_OFF) ? status : 32'h0;
        end
    end

    // Sticky overflow: a dropped byte sets it, writing STATUS bit3 clears it; set wins
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)                       ovf <= 1'b0;
        else if (wr_data && full && !pop)   ovf <= 1'b1;
        else if (wr_stat && HWDATA[ST_OVF]) ovf <= 1'b0;
    end

    // Transmit FSM next-state: every non-idle state lasts DIV cycles of the baud counter
    always_comb begin
        state_n = state;
        cnt_n   = cnt - CNT_W'(1);
        bit_n   = bit_idx;
        shift_n = shift;
        pop     = 1'b0;
`ifdef MFP_UART_TX_PARITY_EN
        par_n   = par;
`endif
        case (state)
            S_IDLE: begin
                cnt_n = DIV_M1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_n = dout;
`ifdef MFP_UART_TX_PARITY_EN
                    par_n   = ^dout;
`endif
                    state_n = S_START;
                end
            end
            S_START: if (cnt == '0) begin
                cnt_n   = DIV_M1;
                bit_n   = 3'd0;
                state_n = S_DATA;
            end
            S_DATA: if (cnt == '0) begin
                cnt_n   = DIV_M1;
                shift_n = {1'b0, shift[7:1]};
                bit_n   = bit_idx + 3'd1;
                if (bit_idx == 3'd7) begin
`ifdef MFP_UART_TX_PARITY_EN
                    state_n = S_PARITY;
`else
                    state_n = S_STOP;
`endif
                end
            end
`ifdef MFP_UART_TX_PARITY_EN
            S_PARITY: if (cnt == '0) begin
                cnt_n   = DIV_M1;
                state_n = S_STOP;
            end
`endif
            S_STOP: if (cnt == '0) begin
                cnt_n = DIV_M1;
                if (!empty) begin
                    // chain straight into the next frame without an idle bit
                    pop     = 1'b1;
                    shift_n = dout;
`ifdef MFP_UART_TX_PARITY_EN
                    par_n   = ^dout;
`endif
                    state_n = S_START;
                end else begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        case (state_n)
            S_START:  tx_n = 1'b0;
            S_DATA:   tx_n = shift_n[0];
`ifdef MFP_UART_TX_PARITY_EN
            S_PARITY: tx_n = par_n;
`endif
            default:  tx_n = 1'b1;
        endcase
    end

    // FSM, baud counter, shifter and registered line output; reset aborts any frame
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'h0;
            UART_TX <= 1'b1;
`ifdef MFP_UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            shift   <= shift_n;
            UART_TX <= tx_n;
`ifdef MFP_UART_TX_PARITY_EN
            par     <= par_n;
`endif
        end
    end

endmodule

// File: tb/tb_mfp_ahb_uart_tx.sv
// Testbench for mfp_ahb_uart_tx (DIV=10, FIFO_DEPTH=4). The reference model
// keeps a list of accepted frames with their start cycles and derives the
// line level, FIFO occupancy and STATUS for any cycle from that list.
module tb_mfp_ahb_uart_tx;
    localparam int DIV   = 10;
    localparam int DEPTH = 4;
`ifdef MFP_UART_TX_PARITY_EN
    localparam int  FL   = 11;
    localparam bit  PAR  = 1'b1;
    localparam logic [31:0] PB = 32'h10;
`else
    localparam int  FL   = 10;
    localparam bit  PAR  = 1'b0;
    localparam logic [31:0] PB = 32'h0;
`endif

    logic        HCLK = 1'b0, HRESETn = 1'b0, HSEL = 1'b0, HWRITE = 1'b0, HREADY = 1'b1;
    logic [31:0] HADDR = 32'h0, HWDATA = 32'h0;
    logic [1:0]  HTRANS = 2'b00;
    logic [2:0]  HSIZE = 3'b010;
    logic [31:0] HRDATA;
    logic        HREADYOUT, HRESP, UART_TX;

    mfp_ahb_uart_tx #(.CLK_FREQ(1000), .BAUD(100), .FIFO_DEPTH(DEPTH)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .UART_TX(UART_TX)
    );

    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    int n_cmp = 0, n_bad = 0;
    bit started = 1'b0;

    // ---------------- reference model ----------------
    int         fr_p [4096];   // cycle from which the byte is in the FIFO
    int         fr_s [4096];   // first cycle of its start bit
    logic [7:0] fr_d [4096];
    int         nf = 0;
    int         prev_end = 0;
    int         ev_t [$];
    bit         ev_v [$];
    int         rd_at = -1;
    logic [31:0] rd_exp = 32'h0;

    function automatic void model_reset();
        nf = 0; prev_end = 0; rd_at = -1;
        ev_t.delete(); ev_v.delete();
    endfunction

    function automatic int pending_after(int n);
        int c = 0;
        for (int i = 0; i < nf; i++) if (fr_s[i] > n) c++;
        return c;
    endfunction

    function automatic int cnt_at(int n);
        int c = 0;
        for (int i = 0; i < nf; i++) if (fr_p[i] <= n && fr_s[i] > n) c++;
        return c;
    endfunction

    function automatic int frame_at(int n);
        for (int i = 0; i < nf; i++)
            if (fr_s[i] <= n && n < fr_s[i] + FL*DIV) return i;
        return -1;
    endfunction

    function automatic logic line_at(int n);
        int i, k;
        i = frame_at(n);
        if (i < 0) return 1'b1;
        k = (n - fr_s[i]) / DIV;
        if (k == 0) return 1'b0;
        if (k <= 8) return fr_d[i][k-1];
        if (PAR && k == 9) return ^fr_d[i];
        return 1'b1;
    endfunction

    function automatic logic ovf_at(int n);
        logic v = 1'b0;
        foreach (ev_t[j]) if (ev_t[j] <= n) v = ev_v[j];
        return v;
    endfunction

    function automatic logic [31:0] status_at(int n);
        int c;
        logic [31:0] s;
        c = cnt_at(n);
        s = PB | (32'(c) << 8);
        if (ovf_at(n))      s = s | 32'h8;
        if (frame_at(n) >= 0) s = s | 32'h4;
        if (c == 0)         s = s | 32'h2;
        if (c == DEPTH)     s = s | 32'h1;
        return s;
    endfunction

    // d = data-phase cycle; effects become visible from cycle d+1
    function automatic void model_write(logic [1:0] a, logic [31:0] wd, int d);
        int s;
        if (a == 2'd0) begin
            if (pending_after(d + 1) < DEPTH) begin
                s = (d + 2 > prev_end) ? d + 2 : prev_end;
                fr_p[nf] = d + 1; fr_s[nf] = s; fr_d[nf] = wd[7:0];
                prev_end = s + FL*DIV;
                nf++;
            end else begin
                ev_t.push_back(d + 1); ev_v.push_back(1'b1);
            end
        end else if (a == 2'd1 && wd[3]) begin
            ev_t.push_back(d + 1); ev_v.push_back(1'b0);
        end
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge HCLK) begin
        if (started) begin
            chk("uart_tx", 32'(UART_TX), HRESETn ? 32'(line_at(cyc)) : 32'h1);
            chk("hreadyout", 32'(HREADYOUT), 32'h1);
            chk("hresp", 32'(HRESP), 32'h0);
            if (cyc == rd_at) chk("hrdata", HRDATA, rd_exp);
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- bus tasks (entered #1 after a rising edge) ----------------
    task automatic ahb_xfer(input logic [1:0] a, input logic wr, input logic [31:0] wd,
                            output int d, output logic [31:0] rd);
        HSEL = 1'b1; HTRANS = 2'b10; HREADY = 1'b1; HWRITE = wr; HADDR = {28'h0, a, 2'b00};
        @(posedge HCLK); #1;
        d = cyc;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = wd;
        if (wr) model_write(a, wd, d);
        else begin
            rd_exp = (a == 2'd1) ? status_at(d - 1) : 32'h0;
            rd_at  = d;
        end
        @(negedge HCLK); rd = HRDATA;
        @(posedge HCLK); #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] wd, output int d);
        logic [31:0] rd;
        ahb_xfer(a, 1'b1, wd, d, rd);
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [31:0] rd);
        int d;
        ahb_xfer(a, 1'b0, 32'h0, d, rd);
    endtask

    task automatic at_cycle(input int n);
        do @(negedge HCLK); while (cyc < n);
    endtask

    task automatic resync();
        @(posedge HCLK); #1;
    endtask

    initial begin
        int d, d1, da, op, v, tgt;
        logic [31:0] r;
        logic [9:0] pat55;
        pat55 = 10'b1010101010;

        // reset state
        HRESETn = 1'b0;
        repeat (3) @(posedge HCLK);
        #1; HRESETn = 1'b1; started = 1'b1;
        resync();
        rd_reg(2'd1, r); chk("status_after_reset", r, 32'h2 | PB);
        rd_reg(2'd0, r); chk("txdata_read", r, 32'h0);

        // single 0x55 frame, pinned bit by bit
        wr(2'd0, 32'h55, d);
        at_cycle(d + 1); chk("latency_idle", 32'(UART_TX), 32'h1);
        for (int i = 0; i < 9; i++) begin
            at_cycle(d + 2 + i*DIV + 5);
            chk("frame55_bit", 32'(UART_TX), 32'(pat55[i]));
        end
        at_cycle(d + 2 + (FL-1)*DIV + 5); chk("frame55_stop", 32'(UART_TX), 32'h1);
        at_cycle(d + 2 + FL*DIV + 2); resync();
        rd_reg(2'd1, r); chk("status_idle_after_frame", r, 32'h2 | PB);

        // three queued bytes go out back to back
        wr(2'd0, 32'h01, d1); wr(2'd0, 32'h02, d); wr(2'd0, 32'h03, d);
        rd_reg(2'd1, r); chk("status_two_queued", r, 32'h204 | PB);
        at_cycle(d1 + 2 + FL*DIV - 1); chk("b2b_last_stop", 32'(UART_TX), 32'h1);
        at_cycle(d1 + 2 + FL*DIV);     chk("b2b_next_start", 32'(UART_TX), 32'h0);
        at_cycle(prev_end + 2); resync();

        // overflow: one popped, four queued, sixth dropped
        for (int i = 0; i < 6; i++) wr(2'd0, 32'(8'hB0 + i), d);
        rd_reg(2'd1, r); chk("status_ovf_full", r, 32'h40D | PB);
        wr(2'd1, 32'h8, d);
        rd_reg(2'd1, r); chk("status_ovf_cleared", r, 32'h405 | PB);
        at_cycle(prev_end + 2); resync();

`ifdef MFP_UART_TX_PARITY_EN
        wr(2'd0, 32'h07, d);
        at_cycle(d + 2 + 9*DIV + 5);  chk("parity_07", 32'(UART_TX), 32'h1);
        at_cycle(d + 2 + 10*DIV + 5); chk("stop_07", 32'(UART_TX), 32'h1);
        at_cycle(prev_end + 2); resync();
        wr(2'd0, 32'h03, d);
        at_cycle(d + 2 + 9*DIV + 5);  chk("parity_03", 32'(UART_TX), 32'h0);
        at_cycle(prev_end + 2); resync();
`endif

        // reset in the middle of data bit 3 of 0xA5 with two bytes queued
        wr(2'd0, 32'hA5, da); wr(2'd0, 32'h11, d); wr(2'd0, 32'h22, d);
        at_cycle(da + 2 + 4*DIV + 5);
        chk("a5_bit3_before_reset", 32'(UART_TX), 32'h0);
        #2; HRESETn = 1'b0; model_reset();
        #1; chk("tx_high_in_reset", 32'(UART_TX), 32'h1);
        @(posedge HCLK); @(posedge HCLK); #1; HRESETn = 1'b1;
        rd_reg(2'd1, r); chk("status_after_midframe_reset", r, 32'h2 | PB);
        repeat (3*FL*DIV) @(posedge HCLK);
        #1;

        // randomized traffic
        for (int it = 0; it < 600; it++) begin
            op = $urandom_range(0, 9);
            if (op <= 4) wr(2'd0, $urandom, d);
            else if (op == 5) rd_reg(2'd1, r);
            else if (op == 6) rd_reg(2'd0, r);
            else if (op == 7) wr(2'd1, $urandom, d);
            else if (op == 8) begin
                v = $urandom_range(0, 2);
                HSEL = (v != 0); HTRANS = (v == 1) ? 2'b01 : 2'b10; HREADY = (v != 2);
                HWRITE = 1'b1; HADDR = 32'h0;
                resync();
                HSEL = 1'b0; HTRANS = 2'b00; HREADY = 1'b1; HWRITE = 1'b0; HWDATA = $urandom;
                resync();
            end else begin
                repeat ($urandom_range(0, 60)) @(posedge HCLK);
                #1;
            end
        end
        rd_reg(2'd1, r);

        tgt = prev_end + 5;
        if (tgt <= cyc) tgt = cyc + 1;
        at_cycle(tgt);
        resync();
        rd_reg(2'd1, r);
        at_cycle(cyc + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
